// File: rtl/control_unit.sv
// control_unit -- instruction-sequencing FSM for the Lab B processor.
//
// Steps Init -> Fetch -> Decode -> execute state(s) -> Fetch. It drives the
// PC clear/increment requests and the IR load strobe. It also drives the
// data-memory, register-file and ALU controls for each decoded 16-bit
// instruction.
//
// Ports:
//   Clock       in   rising-edge clock shared with PC, IR, RF, data memory
//   ResetN      in   synchronous active-low reset (forces Init)
//   IR          in   16-bit instruction register contents
//   PC_clr      out  PC clear request
//   PC_up       out  PC increment request
//   IR_ld       out  IR load strobe
//   D_addr      out  8-bit data-memory address
//   D_wr        out  data-memory write enable
//   RF_s        out  RF write-data select (1 = memory, 0 = ALU)
//   RF_W_addr   out  RF write address
//   RF_W_wr     out  RF write enable
//   RF_Ra_addr  out  RF read port A address
//   RF_Rb_addr  out  RF read port B address
//   ALU_s0      out  ALU function (0 pass, 1 add, 2 sub)
//   State       out  current state encoding (debug)
module control_unit (
  input  logic        Clock,
  input  logic        ResetN,
  input  logic [15:0] IR,
  output logic        PC_clr,
  output logic        PC_up,
  output logic        IR_ld,
  output logic [7:0]  D_addr,
  output logic        D_wr,
  output logic        RF_s,
  output logic [3:0]  RF_W_addr,
  output logic        RF_W_wr,
  output logic [3:0]  RF_Ra_addr,
  output logic [3:0]  RF_Rb_addr,
  output logic [2:0]  ALU_s0,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOP    = 4'd3,
    S_LOADA  = 4'd4,
    S_LOADB  = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'd0,
    OP_STORE = 4'd1,
    OP_LOAD  = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_HALT  = 4'd5
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2
  } alu_t;

  state_t  state;
  opcode_t op;

  // Opcodes 6..15 fall through to the default arms and behave as NOOP.
  assign op = opcode_t'(IR[15:12]);

  // Instruction field map.
  logic [7:0] store_addr;
  logic [7:0] load_addr;
  logic [3:0] ra_field;
  logic [3:0] rb_field;
  logic [3:0] w_field;

  assign store_addr = IR[7:0];
  assign load_addr  = IR[11:4];
  assign ra_field   = IR[11:8];
  assign rb_field   = IR[7:4];
  assign w_field    = IR[3:0];

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state <= S_INIT;
    end else begin
      case (state)
        S_INIT:   state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_STORE: state <= S_STORE;
            OP_LOAD:  state <= S_LOADA;
            OP_ADD:   state <= S_ADD;
            OP_SUB:   state <= S_SUB;
            OP_HALT:  state <= S_HALT;
            default:  state <= S_NOP;
          endcase
        end
        S_LOADA:  state <= S_LOADB;
        S_LOADB:  state <= S_FETCH;
        S_NOP,
        S_STORE,
        S_ADD,
        S_SUB:    state <= S_FETCH;
        S_HALT:   state <= S_HALT;
        default:  state <= S_INIT;
      endcase
    end
  end

  // Moore decode. The outputs depend only on the state register and the IR
  // fields. IR is stable from Decode until the next Fetch edge, so no output
  // register is needed to keep the strobes glitch-consistent within a cycle.
  always_comb begin
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    IR_ld      = 1'b0;
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_wr    = 1'b0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s0     = ALU_PASS;
    case (state)
      S_INIT: PC_clr = 1'b1;
      S_FETCH: begin
        IR_ld = 1'b1;
        PC_up = 1'b1;
      end
      S_DECODE: begin
        // Present addresses early; no strobes fire here.
        case (op)
          OP_STORE: begin
            D_addr     = store_addr;
            RF_Ra_addr = ra_field;
          end
          OP_LOAD: D_addr = load_addr;
          OP_ADD,
          OP_SUB: begin
            RF_Ra_addr = ra_field;
            RF_Rb_addr = rb_field;
          end
          default: ;
        endcase
      end
      S_LOADA, S_LOADB: begin
        // The address is held across both cycles to cover the 1-cycle
        // memory read latency. Only LoadB writes the RF.
        D_addr    = load_addr;
        RF_W_addr = w_field;
        RF_s      = 1'b1;
        RF_W_wr   = (state == S_LOADB);
      end
      S_STORE: begin
        D_addr     = store_addr;
        RF_Ra_addr = ra_field;
        D_wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = ra_field;
        RF_Rb_addr = rb_field;
        RF_W_addr  = w_field;
        RF_W_wr    = 1'b1;
        ALU_s0     = (state == S_SUB) ? ALU_SUB : ALU_ADD;
      end
      default: ;
    endcase
  end

  assign State = state;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit -- self-checking bench for control_unit.
// It drives the IR the way the real IR register would after each Fetch
// cycle. It compares every output on every cycle against a per-instruction
// expected cycle sequence.
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        ResetN;
  logic [15:0] IR;
  logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_wr;
  logic [7:0]  D_addr;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, State;
  logic [2:0]  ALU_s0;

  control_unit dut (
    .Clock      (Clock),
    .ResetN     (ResetN),
    .IR         (IR),
    .PC_clr     (PC_clr),
    .PC_up      (PC_up),
    .IR_ld      (IR_ld),
    .D_addr     (D_addr),
    .D_wr       (D_wr),
    .RF_s       (RF_s),
    .RF_W_addr  (RF_W_addr),
    .RF_W_wr    (RF_W_wr),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .ALU_s0     (ALU_s0),
    .State      (State)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_clr;
    logic       pc_up;
    logic       ir_ld;
    logic [7:0] d_addr;
    logic       d_wr;
    logic       rf_s;
    logic [3:0] w_addr;
    logic       w_wr;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] alu;
  } outs_t;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  outs_t       exp_q[$];

  function automatic outs_t observe();
    outs_t o;
    o = {State, PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s,
         RF_W_addr, RF_W_wr, RF_Ra_addr, RF_Rb_addr, ALU_s0};
    return o;
  endfunction

  function automatic outs_t rec_init();
    outs_t r = '0;
    r.pc_clr = 1'b1;
    return r;
  endfunction

  function automatic outs_t rec_fetch();
    outs_t r = '0;
    r.state = 4'd1;
    r.pc_up = 1'b1;
    r.ir_ld = 1'b1;
    return r;
  endfunction

  // Reference model: the full list of per-cycle outputs an instruction
  // produces, from its Fetch cycle through its last execute cycle.
  task automatic build_seq(input logic [15:0] ir);
    outs_t r;
    int op;
    op = int'(ir[15:12]);
    exp_q.delete();
    exp_q.push_back(rec_fetch());
    r = '0;
    r.state = 4'd2;
    if (op == 1) begin r.d_addr = ir[7:0]; r.ra = ir[11:8]; end
    if (op == 2) r.d_addr = ir[11:4];
    if (op == 3 || op == 4) begin r.ra = ir[11:8]; r.rb = ir[7:4]; end
    exp_q.push_back(r);
    r = '0;
    case (op)
      1: begin
        r.state = 4'd6; r.d_addr = ir[7:0]; r.ra = ir[11:8]; r.d_wr = 1'b1;
        exp_q.push_back(r);
      end
      2: begin
        r.state = 4'd4; r.d_addr = ir[11:4]; r.w_addr = ir[3:0]; r.rf_s = 1'b1;
        exp_q.push_back(r);
        r.state = 4'd5; r.w_wr = 1'b1;
        exp_q.push_back(r);
      end
      3, 4: begin
        r.state = (op == 3) ? 4'd7 : 4'd8;
        r.ra = ir[11:8]; r.rb = ir[7:4]; r.w_addr = ir[3:0];
        r.w_wr = 1'b1;
        r.alu = (op == 3) ? 3'd1 : 3'd2;
        exp_q.push_back(r);
      end
      5: begin
        r.state = 4'd9;
        exp_q.push_back(r);
      end
      default: begin
        r.state = 4'd3;
        exp_q.push_back(r);
      end
    endcase
  endtask

  task automatic test_reset(input string tag);
    outs_t obs;
    ResetN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      obs = observe();
      n_checks++;
      if (obs !== rec_init())
        $display("FAIL reset_hold_%s cyc%0d got %h want %h", tag, i, obs, rec_init());
      else n_pass++;
    end
    ResetN = 1'b1;
    @(negedge Clock);
    obs = observe();
    n_checks++;
    if (obs !== rec_fetch())
      $display("FAIL reset_release_%s got %h want %h", tag, obs, rec_fetch());
    else n_pass++;
  endtask

  // Starts and ends at a negedge with the DUT in Fetch.
  task automatic test_instructions();
    logic [15:0] tbl [5];
    outs_t obs;
    tbl[0] = 16'h2A53; tbl[1] = 16'h1B42; tbl[2] = 16'h3127;
    tbl[3] = 16'h4127; tbl[4] = 16'hF123;
    for (int t = 0; t < 5; t++) begin
      build_seq(tbl[t]);
      for (int i = 0; i < exp_q.size(); i++) begin
        obs = observe();
        n_checks++;
        if (obs !== exp_q[i])
          $display("FAIL instr_%h cyc%0d got %h want %h", tbl[t], i, obs, exp_q[i]);
        else n_pass++;
        if (i == 0) IR = tbl[t];
        @(negedge Clock);
      end
      n_checks++;
      if (State !== 4'd1)
        $display("FAIL instr_%h_return got state %0d want 1", tbl[t], State);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ir;
    outs_t obs;
    for (int t = 0; t < 120; t++) begin
      ir = 16'($urandom);
      if (ir[15:12] == 4'd5) ir[15:12] = 4'd0;
      build_seq(ir);
      for (int i = 0; i < exp_q.size(); i++) begin
        obs = observe();
        n_checks++;
        if (obs !== exp_q[i])
          $display("FAIL random_%h cyc%0d got %h want %h", ir, i, obs, exp_q[i]);
        else n_pass++;
        n_checks++;
        if ((PC_clr & PC_up) !== 1'b0 || (D_wr & RF_W_wr) !== 1'b0)
          $display("FAIL exclusive_strobes got clr/up=%b%b dwr/wwr=%b%b want no pair",
                   PC_clr, PC_up, D_wr, RF_W_wr);
        else n_pass++;
        if (i == 0) IR = ir;
        @(negedge Clock);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    outs_t obs;
    n_checks++;
    if (State !== 4'd1) $display("FAIL midload_start got state %0d want 1", State);
    else n_pass++;
    IR = {4'd2, 12'($urandom)};
    @(negedge Clock);
    @(negedge Clock);
    n_checks++;
    if (State !== 4'd4) $display("FAIL midload_loada got state %0d want 4", State);
    else n_pass++;
    ResetN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clock);
      obs = observe();
      n_checks++;
      if (obs !== rec_init())
        $display("FAIL midload_abort cyc%0d got %h want %h", i, obs, rec_init());
      else n_pass++;
    end
    ResetN = 1'b1;
    @(negedge Clock);
    obs = observe();
    n_checks++;
    if (obs !== rec_fetch())
      $display("FAIL midload_refetch got %h want %h", obs, rec_fetch());
    else n_pass++;
  endtask

  task automatic test_halt();
    outs_t obs;
    outs_t halt_rec;
    halt_rec = '0;
    halt_rec.state = 4'd9;
    build_seq(16'h5000);
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = observe();
      n_checks++;
      if (obs !== exp_q[i])
        $display("FAIL halt_enter cyc%0d got %h want %h", i, obs, exp_q[i]);
      else n_pass++;
      if (i == 0) IR = 16'h5000;
      if (i < exp_q.size() - 1) @(negedge Clock);
    end
    for (int i = 0; i < 20; i++) begin
      IR = 16'($urandom);
      @(negedge Clock);
      obs = observe();
      n_checks++;
      if (obs !== halt_rec)
        $display("FAIL halt_hold cyc%0d got %h want %h", i, obs, halt_rec);
      else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  initial begin
    ResetN = 1'b0;
    IR     = '0;
    test_reset("power_up");
    test_instructions();
    test_back_to_back();
    test_reset_mid_load();
    test_halt();
    test_reset("from_halt");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
